// File: rtl/fifo_flags_if.sv
// Handshake and status bundle between a FIFO and the stage that fills/drains it.
// The master drives push/pop/data_in; the slave (the FIFO) drives data and flags.
interface fifo_flags_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  error;

    modport master (
        output push,
        output pop,
        output data_in,
        input  data_out,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  fill_level,
        input  error
    );

    modport slave (
        input  push,
        input  pop,
        input  data_in,
        output data_out,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output fill_level,
        output error
    );
endinterface

// File: rtl/fifo_flags.sv
// Single-clock FIFO with registered read data, occupancy-derived flags and a
// sticky overflow/underflow error bit.
module fifo_flags #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    fifo_flags_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   LP_DEPTH   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LP_AF      = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   LP_AE      = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE = ADDR_WIDTH'(1);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_flags: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flags: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_error;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_overflow;
    logic                  w_underflow;
    logic [ADDR_WIDTH:0]   w_count_d;

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign w_push_ok   = bus.push && (!w_full || bus.pop);
    assign w_pop_ok    = bus.pop && !w_empty;
    assign w_overflow  = bus.push && w_full && !bus.pop;
    assign w_underflow = bus.pop && w_empty;

    always_comb begin
        w_count_d = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_d = r_count + LP_CNT_ONE;
            2'b01:   w_count_d = r_count - LP_CNT_ONE;
            default: w_count_d = r_count;
        endcase
    end

    // Storage has no reset; writes are suppressed while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (i_reset && w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + LP_PTR_ONE;
            end
            r_count <= w_count_d;
            if (w_overflow || w_underflow) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= LP_AF);
    assign bus.almost_empty = (r_count <= LP_AE);
    assign bus.fill_level   = r_count;
    assign bus.error        = r_error;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed self-checking bench for fifo_flags: fill/drain, wrap, full and empty
// boundaries, sticky error and reset mid-operation.
module tb_fifo_flags;

    localparam int unsigned DW = 10;
    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_flags #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected flags follow from fill with AF_THRESH=6, AE_THRESH=1, DEPTH=8.
    task automatic check_state(input string tag, input int fill);
        check_eq({tag, ".fill"},  32'(bus.fill_level),   32'(fill));
        check_eq({tag, ".empty"}, 32'(bus.empty),        32'(fill == 0));
        check_eq({tag, ".full"},  32'(bus.full),         32'(fill == 8));
        check_eq({tag, ".af"},    32'(bus.almost_full),  32'(fill >= 6));
        check_eq({tag, ".ae"},    32'(bus.almost_empty), 32'(fill <= 1));
    endtask

    task automatic step(input logic rst_n, input logic p, input logic q, input logic [DW-1:0] d);
        @(negedge clk);
        reset        = rst_n;
        bus.push     = p;
        bus.pop      = q;
        bus.data_in  = d;
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] words [8];

    initial begin
        words[0] = 10'h180; words[1] = 10'h060; words[2] = 10'h018; words[3] = 10'h006;
        words[4] = 10'h38C; words[5] = 10'h06F; words[6] = 10'h018; words[7] = 10'h306;

        reset       = 1'b0;
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.data_in = 10'h3FF;

        // Reset held two cycles with push/pop active, then one idle cycle.
        step(1'b0, 1'b1, 1'b1, 10'h3FF);
        step(1'b0, 1'b1, 1'b1, 10'h3FF);
        check_state("reset", 0);
        check_eq("reset.dout", 32'(bus.data_out), 32'h0);
        check_eq("reset.err",  32'(bus.error),    32'h0);
        step(1'b1, 1'b0, 1'b0, 10'h000);
        check_state("idle", 0);

        // Fill to full, then drain in order.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 1'b0, words[k]);
            check_state($sformatf("fill%0d", k + 1), k + 1);
        end
        check_eq("fill.err", 32'(bus.error), 32'h0);
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b0, 1'b1, 10'h000);
            check_eq($sformatf("drain%0d.dout", j), 32'(bus.data_out), 32'(words[j]));
            check_state($sformatf("drain%0d", j), 7 - j);
        end

        // Wrap-around at fill 3 with simultaneous push/pop.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 10'(10'h101 + k));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1, 10'(i + 1));
            check_eq($sformatf("wrap%0d.dout", i), 32'(bus.data_out),
                     (i < 3) ? 32'(10'h101 + i) : 32'(i - 2));
            check_eq($sformatf("wrap%0d.fill", i), 32'(bus.fill_level), 32'd3);
        end
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 1'b0, 1'b1, 10'h000);
            check_eq($sformatf("wrapdrain%0d", j), 32'(bus.data_out), 32'(10'h012 + j));
        end
        check_state("wrapend", 0);
        check_eq("wrap.err", 32'(bus.error), 32'h0);

        // Full boundary: push+pop at full, then overflow.
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 10'(10'h200 + k));
        check_state("full8", 8);
        step(1'b1, 1'b1, 1'b1, 10'h3FF);
        check_eq("fullpp.dout", 32'(bus.data_out), 32'h200);
        check_state("fullpp", 8);
        check_eq("fullpp.err", 32'(bus.error), 32'h0);
        step(1'b1, 1'b1, 1'b0, 10'h2AA);
        check_eq("ovf.err",  32'(bus.error),    32'h1);
        check_eq("ovf.dout", 32'(bus.data_out), 32'h200);
        check_state("ovf", 8);
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b0, 1'b1, 10'h000);
            check_eq($sformatf("ovfdrain%0d", j), 32'(bus.data_out),
                     (j < 7) ? 32'(10'h201 + j) : 32'h3FF);
        end
        check_state("ovfend", 0);

        // Empty boundary from a clean error state, with a known data_out.
        step(1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b1, 1'b1, 1'b0, 10'h0F0);
        step(1'b1, 1'b0, 1'b1, 10'h000);
        check_eq("pre.dout", 32'(bus.data_out), 32'h0F0);
        check_eq("pre.err",  32'(bus.error),    32'h0);
        step(1'b1, 1'b1, 1'b1, 10'h155);
        check_eq("udf.err",  32'(bus.error),    32'h1);
        check_eq("udf.dout", 32'(bus.data_out), 32'h0F0);
        check_state("udf", 1);
        step(1'b1, 1'b0, 1'b1, 10'h000);
        check_eq("udf.next", 32'(bus.data_out), 32'h155);
        check_state("udfnext", 0);

        // Sticky error at fill 5, then reset (with push asserted) mid-operation.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 10'(10'h040 + k));
        step(1'b1, 1'b0, 1'b0, 10'h000);
        check_eq("sticky.err", 32'(bus.error), 32'h1);
        check_state("sticky", 5);
        step(1'b0, 1'b1, 1'b0, 10'h3C3);
        check_eq("rst.err",  32'(bus.error),    32'h0);
        check_eq("rst.dout", 32'(bus.data_out), 32'h0);
        check_state("rst", 0);
        step(1'b1, 1'b0, 1'b0, 10'h000);
        check_state("rstidle", 0);

        // Bare underflow leaves data_out and count alone.
        step(1'b1, 1'b0, 1'b1, 10'h000);
        check_eq("udf2.err",  32'(bus.error),    32'h1);
        check_eq("udf2.dout", 32'(bus.data_out), 32'h0);
        check_state("udf2", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_flags.md
# fifo_flags

Synchronous single-clock FIFO that buffers 10-bit packet words between pipeline stages. It implements each of the eight queues around the round-robin arbiter: the four input queues P0–P3, which the arbiter pops, and the four output queues P4–P7, which it pushes. It supplies the `empty` and `almost_full` flags the arbiter arbitrates on. It also reports full, almost-empty, fill level and a sticky error on overflow or underflow.

## Interface
Parameters:
- `DATA_WIDTH`, 10: word width.
- `ADDR_WIDTH`, 3: pointer width; `DEPTH` = 2^ADDR_WIDTH = 8 entries.
- `AF_THRESH`, 6: `almost_full` asserts when fill ≥ this value; legal range 1..DEPTH.
- `AE_THRESH`, 1: `almost_empty` asserts when fill ≤ this value; legal range 0..DEPTH-1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the `clk` rising edge.
- `push` input 1: write request for `data_in`.
- `pop` input 1: read request.
- `data_in` input DATA_WIDTH: word to write.
- `data_out` output DATA_WIDTH: registered read data.
- `full` output 1: fill == DEPTH.
- `empty` output 1: fill == 0.
- `almost_full` output 1: fill ≥ AF_THRESH.
- `almost_empty` output 1: fill ≤ AE_THRESH.
- `fill_level` output ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `error` output 1: sticky overflow/underflow indication.

## Operation
- Storage is a DEPTH × DATA_WIDTH register array with write pointer `wr_ptr`, read pointer `rd_ptr` (ADDR_WIDTH bits each) and occupancy counter `count` (ADDR_WIDTH+1 bits).
- Pointers wrap modulo DEPTH: DEPTH-1 increments to 0. Storage contents are never cleared.
- Accepted push (`push` && (!full || pop)):
  - `mem[wr_ptr]` ← `data_in`.
  - `wr_ptr` increments.
- Accepted pop (`pop` && !empty):
  - `data_out` ← `mem[rd_ptr]`.
  - `rd_ptr` increments.
- When there is no accepted pop, `data_out` holds its last value.
- `count` update per edge:
  - +1 on an accepted push alone.
  - −1 on an accepted pop alone.
  - Unchanged when both are accepted, or when neither is.
- Simultaneous push and pop:
  - Not empty and not full: both proceed; `count` is unchanged.
  - Full: the pop frees a slot, so both proceed. `count` stays at DEPTH; no error.
  - Empty: the pop is rejected, which is an underflow. The push proceeds and `count` becomes 1.
- Overflow: `push` && full && !pop.
  - The word is dropped; pointers and `count` are unchanged.
  - `error` is set.
- Underflow: `pop` && empty.
  - Pointers, `count` and `data_out` are unchanged.
  - `error` is set.
- `error` stays at 1 until reset; no other event clears it.
- Flags and `fill_level` are combinational decodes of the registered `count` only. There is no combinational path from `push` or `pop` to any flag.

## Timing
- Reset: when `reset` is 0 at a rising edge, the following are cleared on that edge: `wr_ptr`, `rd_ptr`, `count`, `data_out` (to 0) and `error`.
- Values after reset:
  - `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `fill_level`=0.
  - These hold because AE_THRESH ≥ 0 and AF_THRESH ≥ 1.
- Reset mid-operation: reset wins over any simultaneous `push` or `pop` in the same cycle. Buffered words are discarded.
- Write latency: a word pushed at edge N is poppable at edge N+1, since `empty` deasserts after edge N.
- Read latency: a word popped at edge N appears on `data_out` after edge N. It is valid for the consumer to sample during cycle N+1.
- Flag latency: all flags reflect the pushes and pops of edge N immediately after edge N, with one cycle of latency from the request.
- Throughput: one push and one pop per cycle, sustained indefinitely.

## Test plan
- Reset and idle:
  - Stimulus: hold `reset`=0 for 2 cycles with `push`=`pop`=1, then release.
  - Required: `empty`=1, `almost_empty`=1, `fill_level`=0, `data_out`=0, `error`=0; nothing is written.
- Fill to full:
  - Stimulus: push 0x180, 0x060, 0x018, 0x006, 0x38C, 0x06F, 0x018, 0x306 on consecutive cycles.
  - Required: `almost_empty` drops when fill reaches 2. `almost_full` rises after the 6th push. `full` rises after the 8th, with `fill_level`=8 and `error`=0.
  - Then pop 8 times: `data_out` reproduces the same sequence in push order. `empty` returns after the 8th pop.
- Wrap-around:
  - Stimulus: 20 cycles of simultaneous push/pop at fill 3, with incrementing data 0x001…0x014.
  - Required: `fill_level` stays 3, output order is preserved across the pointer wrap, and `error`=0.
- Full boundary:
  - Stimulus: at fill 8, push 0x3FF with `pop`=1.
  - Required: the oldest word appears on `data_out`, `fill_level` stays 8, `error`=0.
  - Then push 0x2AA with `pop`=0. Required: `error`=1, `fill_level`=8, and 0x2AA never appears on the output.
- Empty boundary:
  - Stimulus: at fill 0, `pop`=1 with `push`=1 and data 0x155.
  - Required: `error`=1, `data_out` unchanged, `fill_level`=1. The next pop returns 0x155.
- Sticky error and reset mid-operation:
  - Stimulus: with `error`=1 and fill 5, pulse `reset`=0 for 1 cycle.
  - Required: `error`=0, `fill_level`=0, `empty`=1 on the following cycle.
